// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the 32-bit ALU: RV32I ALU-class decode into registered
// {alu_a, alu_b, alu_op} behind a main + skid buffer with a registered in_ready.
module alu_issue_stage #(
    parameter int unsigned ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          rs1_data,
    input  logic [31:0]          rs2_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_op,
    output logic [4:0]           rd,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] F7Zero   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluSlt  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;
    localparam logic [3:0] AluNop  = 4'b1111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    localparam entry_t ResetEntry = '{a: 32'd0, b: 32'd0, op: AluNop, rd: 5'd0, ill: 1'b0};
    localparam entry_t IllEntry   = '{a: 32'd0, b: 32'd0, op: AluNop, rd: 5'd0, ill: 1'b1};

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm;
    logic [31:0] w_shamt;
    logic        w_unused_rs1_idx;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [3:0]  w_op;
    logic        w_ok;
    entry_t      w_dec;

    entry_t                r_main;
    entry_t                r_skid;
    logic                  r_main_valid;
    logic                  r_skid_valid;
    logic                  r_in_ready;
    logic [ILL_CNT_W-1:0]  r_ill_cnt;

    entry_t w_main_d;
    entry_t w_skid_d;
    logic   w_main_valid_d;
    logic   w_skid_valid_d;
    logic   w_in_fire;
    logic   w_main_free;

    assign w_opc   = instr[6:0];
    assign w_f3    = instr[14:12];
    assign w_f7    = instr[31:25];
    assign w_imm   = {{20{instr[31]}}, instr[31:20]};
    assign w_shamt = {27'd0, instr[24:20]};
    // Register indices are resolved upstream; only the data arrives here.
    assign w_unused_rs1_idx = ^instr[19:15];

    always_comb begin
        w_a  = 32'd0;
        w_b  = 32'd0;
        w_op = AluNop;
        w_ok = 1'b0;
        unique case (w_opc)
            OpcOp: begin
                w_a = rs1_data;
                w_b = rs2_data;
                if (w_f7 == F7Zero) begin
                    w_ok = 1'b1;
                    unique case (w_f3)
                        3'b000: w_op = AluAdd;
                        3'b001: w_op = AluSll;
                        3'b010: w_op = AluSlt;
                        3'b011: w_op = AluSltu;
                        3'b100: w_op = AluXor;
                        3'b101: w_op = AluSrl;
                        3'b110: w_op = AluOr;
                        default: w_op = AluAnd;
                    endcase
                end else if (w_f7 == F7Alt && w_f3 == 3'b000) begin
                    w_ok = 1'b1;
                    w_op = AluSub;
                end else if (w_f7 == F7Alt && w_f3 == 3'b101) begin
                    w_ok = 1'b1;
                    w_op = AluSra;
                end
            end
            OpcOpImm: begin
                w_a  = rs1_data;
                w_b  = w_imm;
                w_ok = 1'b1;
                unique case (w_f3)
                    3'b000: w_op = AluAdd;
                    3'b010: w_op = AluSlt;
                    3'b011: w_op = AluSltu;
                    3'b100: w_op = AluXor;
                    3'b110: w_op = AluOr;
                    3'b111: w_op = AluAnd;
                    3'b001: begin
                        w_b  = w_shamt;
                        w_op = AluSll;
                        w_ok = (w_f7 == F7Zero);
                    end
                    default: begin
                        w_b  = w_shamt;
                        w_op = (w_f7 == F7Alt) ? AluSra : AluSrl;
                        w_ok = (w_f7 == F7Zero) || (w_f7 == F7Alt);
                    end
                endcase
            end
            OpcLui: begin
                w_b  = {instr[31:12], 12'd0};
                w_op = AluAdd;
                w_ok = 1'b1;
            end
            default: w_ok = 1'b0;
        endcase
    end

    assign w_dec = w_ok ? '{a: w_a, b: w_b, op: w_op, rd: instr[11:7], ill: 1'b0} : IllEntry;

    assign w_in_fire   = in_valid && r_in_ready;
    assign w_main_free = !r_main_valid || out_ready;

    always_comb begin
        w_main_d       = r_main;
        w_main_valid_d = r_main_valid;
        w_skid_d       = r_skid;
        w_skid_valid_d = r_skid_valid;
        if (w_main_free) begin
            if (r_skid_valid) begin
                // Skid is older than any new arrival, so it must go first.
                w_main_d       = r_skid;
                w_main_valid_d = 1'b1;
                w_skid_valid_d = w_in_fire;
                if (w_in_fire) begin
                    w_skid_d = w_dec;
                end
            end else if (w_in_fire) begin
                w_main_d       = w_dec;
                w_main_valid_d = 1'b1;
            end else begin
                w_main_valid_d = 1'b0;
            end
        end else if (w_in_fire) begin
            w_skid_d       = w_dec;
            w_skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= ResetEntry;
            r_skid       <= ResetEntry;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_ill_cnt    <= '0;
        end else begin
            r_main       <= w_main_d;
            r_skid       <= w_skid_d;
            r_main_valid <= w_main_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_in_ready   <= !w_skid_valid_d;
            if (w_in_fire && w_dec.ill && (r_ill_cnt != '1)) begin
                r_ill_cnt <= r_ill_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign alu_a     = r_main.a;
    assign alu_b     = r_main.b;
    assign alu_op    = r_main.op;
    assign rd        = r_main.rd;
    assign illegal   = r_main.ill;
    assign ill_count = r_ill_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference decoder fills the expected queue on each
// input handshake and a negedge monitor pops/compares on each output handshake.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    logic        in_ready, out_valid, illegal;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [15:0] ill_count;

    logic        in_ready2, out_valid2, illegal2;
    logic [31:0] alu_a2, alu_b2;
    logic [3:0]  alu_op2;
    logic [4:0]  rd2;
    logic [1:0]  ill_count2;

    always #5 clk = ~clk;

    alu_issue_stage #(.ILL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd), .illegal(illegal),
        .ill_count(ill_count)
    );

    alu_issue_stage #(.ILL_CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid2), .out_ready(out_ready),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .rd(rd2), .illegal(illegal2),
        .ill_count(ill_count2)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] st_instr[$];
    logic [31:0] st_rs1[$];
    logic [31:0] st_rs2[$];
    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    logic        hold_v = 1'b0;
    exp_t        hold_e;

    localparam logic [31:0] T_INS [10] = '{32'hFFF00093, 32'h4020D193, 32'h40209193,
        32'h123452B7, 32'h40208233, 32'h022081B3, 32'h8003B313, 32'h00112023, 32'h0041C133,
        32'h0FF0E093};
    localparam logic [31:0] T_R1 [10] = '{32'h0, 32'h80000000, 32'h1234, 32'hDEAD, 32'd10,
        32'd1, 32'h55, 32'd9, 32'hF0F0, 32'h100};
    localparam logic [31:0] T_R2 [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'd3, 32'd2, 32'h0,
        32'd9, 32'h0FF0, 32'h0};
    localparam logic [31:0] T_A [10] = '{32'h0, 32'h80000000, 32'h0, 32'h0, 32'd10, 32'h0,
        32'h55, 32'h0, 32'hF0F0, 32'h100};
    localparam logic [31:0] T_B [10] = '{32'hFFFFFFFF, 32'd2, 32'h0, 32'h12345000, 32'd3,
        32'h0, 32'hFFFFF800, 32'h0, 32'h0FF0, 32'hFF};
    localparam logic [3:0] T_OP [10] = '{4'h0, 4'h7, 4'hF, 4'h0, 4'h1, 4'hF, 4'h9, 4'hF,
        4'h4, 4'h3};
    localparam logic [4:0] T_RD [10] = '{5'd1, 5'd3, 5'd0, 5'd5, 5'd4, 5'd0, 5'd6, 5'd0,
        5'd2, 5'd1};
    localparam logic T_ILL [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [1:0] SAT2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2);
        logic [3:0] lut [8];
        exp_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        lut = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
        f3 = ins[14:12];
        f7 = ins[31:25];
        ok = 1'b0;
        e = '{a: 32'd0, b: 32'd0, op: 4'hF, rd: 5'd0, ill: 1'b1};
        if (ins[6:0] == 7'h33) begin
            e.a = r1;
            e.b = r2;
            if (f7 == 7'h00) begin
                ok = 1'b1;
                e.op = lut[f3];
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                ok = 1'b1;
                e.op = (f3 == 3'd0) ? 4'h1 : 4'h7;
            end
        end else if (ins[6:0] == 7'h13) begin
            e.a = r1;
            e.op = lut[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = {27'd0, ins[24:20]};
                ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'h7;
            end else begin
                e.b = {{20{ins[31]}}, ins[31:20]};
                ok = 1'b1;
            end
        end else if (ins[6:0] == 7'h37) begin
            e.a = 32'd0;
            e.b = {ins[31:12], 12'd0};
            e.op = 4'h0;
            ok = 1'b1;
        end
        if (ok) begin
            e.rd = ins[11:7];
            e.ill = 1'b0;
        end else begin
            e = '{a: 32'd0, b: 32'd0, op: 4'hF, rd: 5'd0, ill: 1'b1};
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        got = {alu_a, alu_b, alu_op, rd, illegal};
        if (!rst) begin
            if (hold_v) begin
                checks++;
                if ({out_valid, got} !== {1'b1, hold_e}) begin
                    errors++;
                    $display("FAIL stall_stable got=%h required=%h", {out_valid, got},
                             {1'b1, hold_e});
                end
            end
            hold_v = 1'b0;
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got=%h required=nothing", got);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL scoreboard got=%h required=%h", got, e);
                    end
                end
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_e = got;
            end
            if (in_valid && in_ready) sb_q.push_back(model(instr, rs1_data, rs2_data));
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic push_stim(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        st_instr.push_back(i);
        st_rs1.push_back(r1);
        st_rs2.push_back(r2);
    endtask

    // Orm: 0 holds out_ready low, 1 holds it high, 2 toggles it every cycle.
    task automatic drive_cycles(input int n, input int orm);
        logic acc;
        for (int c = 0; c < n; c++) begin
            if (st_instr.size() > 0) begin
                in_valid = 1'b1;
                instr    = st_instr[0];
                rs1_data = st_rs1[0];
                rs2_data = st_rs2[0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (orm == 1) || (orm == 2 && (c % 2) == 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(st_instr.pop_front());
                void'(st_rs1.pop_front());
                void'(st_rs2.pop_front());
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        st_instr.delete();
        st_rs1.delete();
        st_rs2.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b required=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
        checks++;
        if ({alu_a, alu_b, alu_op, rd, illegal, ill_count} !== {64'd0, 4'hF, 5'd0, 1'b0, 16'd0})
        begin
            errors++;
            $display("FAIL reset_fields got=%h %h %h %h %b %h required=0 0 f 0 0 0",
                     alu_a, alu_b, alu_op, rd, illegal, ill_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        push_stim(32'h002081B3, 32'd5, 32'd7);
        drive_cycles(1, 1);
        @(negedge clk);
        checks++;
        if ({out_valid, alu_a, alu_b, alu_op, rd, illegal} !==
            {1'b1, 32'd5, 32'd7, 4'h0, 5'd3, 1'b0}) begin
            errors++;
            $display("FAIL add_latency got=%b %h %h %h %h %b required=1 5 7 0 3 0",
                     out_valid, alu_a, alu_b, alu_op, rd, illegal);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push_stim(T_INS[k], T_R1[k], T_R2[k]);
            drive_cycles(1, 1);
            @(negedge clk);
            checks++;
            if ({out_valid, alu_a, alu_b, alu_op, rd, illegal} !==
                {1'b1, T_A[k], T_B[k], T_OP[k], T_RD[k], T_ILL[k]}) begin
                errors++;
                $display("FAIL decode_%0d got=%b %h %h %h %h %b required=1 %h %h %h %h %b", k,
                         out_valid, alu_a, alu_b, alu_op, rd, illegal,
                         T_A[k], T_B[k], T_OP[k], T_RD[k], T_ILL[k]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if ({ill_count, ill_count2} !== {16'd3, 2'd3}) begin
            errors++;
            $display("FAIL decode_ill_count got=%0d/%0d required=3/3", ill_count, ill_count2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        for (int k = 0; k < 4; k++) push_stim(32'h002081B3, 32'd100 + k, 32'd200 + k);
        drive_cycles(2, 0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_in_ready_low got=%b required=0", in_ready);
        end
        @(posedge clk);
        #1;
        drive_cycles(4, 0);
        checks++;
        if (st_instr.size() != 2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accepted got=%0d pending/out_valid=%b required=2/1",
                     st_instr.size(), out_valid);
        end
        base = n_out;
        drive_cycles(12, 1);
        @(negedge clk);
        checks++;
        if (n_out - base != 4 || sb_q.size() != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain got=%0d out/%0d left/in_ready=%b required=4/0/1",
                     n_out - base, sb_q.size(), in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alternate();
        int base;
        do_reset();
        base = n_out;
        for (int k = 0; k < 12; k++)
            push_stim(T_INS[$urandom_range(0, 9)], $urandom, $urandom);
        drive_cycles(40, 2);
        out_ready = 1'b1;
        drive_cycles(4, 1);
        checks++;
        if (n_out - base != 12 || sb_q.size() != 0 || st_instr.size() != 0) begin
            errors++;
            $display("FAIL alternate_count got=%0d out/%0d left required=12/0",
                     n_out - base, sb_q.size());
        end
    endtask

    task automatic test_ill_sat();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_stim(32'h00000000, 32'd0, 32'd0);
            drive_cycles(1, 1);
            @(negedge clk);
            checks++;
            if (ill_count2 !== SAT2[k] || ill_count !== 16'(k + 1)) begin
                errors++;
                $display("FAIL ill_sat_%0d got=%0d/%0d required=%0d/%0d", k, ill_count2,
                         ill_count, SAT2[k], k + 1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_stim(32'h00000000, 32'd0, 32'd0);
        push_stim(32'h002081B3, 32'd1, 32'd2);
        drive_cycles(3, 0);
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, ill_count} !== {1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL mid_full got=%b %b %0d required=1 0 1", out_valid, in_ready, ill_count);
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        instr    = 32'h00000000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, ill_count, ill_count2} !== {1'b0, 1'b1, 16'd0, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset got=%b %b %0d %0d required=0 1 0 0", out_valid, in_ready,
                     ill_count, ill_count2);
        end
        @(posedge clk);
        #1;
        push_stim(32'h0041C133, 32'h3, 32'h5);
        drive_cycles(4, 1);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL mid_after got=%0d left required=0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_decode();
        test_back_to_back();
        test_alternate();
        test_ill_sat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
